// File: rtl/ifetch.sv
`timescale 1ns/1ps
// ifetch - instruction fetch unit, upstream of if_id/id.
//
// Owns the PC and issues word fetches to instruction memory over a
// req/gnt/rvalid handshake. Returned words are buffered in a small in-order
// FIFO and presented to decode as {inst_o, inst_addr_o} with valid/ready.
// A redirect from ex flushes the FIFO and discards every in-flight fetch.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  instruction buffer entries, power of two, 2..8
//   NOP_INST    value on inst_o while inst_valid_o=0
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   jump_en_i       redirect request from ex
//   jump_addr_i     redirect target, bits [1:0] ignored
//   imem_req_o      fetch request
//   imem_addr_o     fetch address, word aligned
//   imem_gnt_i      memory accepted the request this cycle
//   imem_rvalid_i   read data valid, responses in grant order
//   imem_rdata_i    instruction word
//   inst_valid_o    inst_o/inst_addr_o hold a valid instruction
//   inst_ready_i    downstream consumes the instruction this cycle
//   inst_o          instruction to if_id
//   inst_addr_o     address of inst_o

module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  // Counters hold 0..FIFO_DEPTH inclusive; pointers index FIFO_DEPTH slots.
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic          fetch_en;     // low for the first cycle out of reset
  logic [CW-1:0] outstanding;  // granted, response not yet returned
  logic [CW-1:0] drop;         // outstanding responses to be discarded
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_rd, fifo_wr;
  logic [PW-1:0] aq_rd, aq_wr;

  // Issued-address queue: pairs each response with the address it was
  // fetched from. Its occupancy is exactly 'outstanding'.
  logic [31:0] aq_addr   [FIFO_DEPTH];
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [31:0] fifo_addr [FIFO_DEPTH];

  logic          fetch_grant;
  logic          resp_take;
  logic          resp_drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW:0]   in_use;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_nxt;
  logic          unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  // Words in the buffer plus words still in flight must never exceed the
  // buffer size; this is what makes the FIFO overflow-free.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_o  = fetch_en & (in_use < DEPTH_W);
  assign imem_addr_o = pc;
  assign fetch_grant = imem_req_o & imem_gnt_i;

  // An rvalid with nothing outstanding (e.g. a response owed from before a
  // reset) is ignored.
  assign resp_take = imem_rvalid_i & (outstanding != '0);
  assign resp_drop = resp_take & (drop != '0);

  // A redirect overrides both push and pop: the whole buffer is flushed.
  assign fifo_push = resp_take & ~resp_drop & ~jump_en_i;
  assign fifo_pop  = inst_valid_o & inst_ready_i & ~jump_en_i;

  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = inst_valid_o ? fifo_inst[fifo_rd] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? fifo_addr[fifo_rd] : 32'h0000_0000;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    outstanding_nxt = outstanding;
    drop_nxt        = drop;
    if (fetch_grant && !resp_take) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!fetch_grant && resp_take) begin
      outstanding_nxt = outstanding - 1'b1;
    end
    // On a redirect everything still in flight after this edge is stale,
    // including a grant taken this cycle for the old address. Earlier
    // pending drops are part of 'outstanding', so they accumulate.
    if (jump_en_i) begin
      drop_nxt = outstanding_nxt;
    end else if (resp_drop) begin
      drop_nxt = drop - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_en    <= 1'b0;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      fetch_en    <= 1'b1;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      if (fetch_grant) aq_wr <= aq_wr + 1'b1;
      if (resp_take)   aq_rd <= aq_rd + 1'b1;
      if (jump_en_i) begin
        pc         <= {jump_addr_i[31:2], 2'b00};
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
      end else begin
        // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
        if (fetch_grant) pc <= pc + 32'd4;
        if (fifo_push)   fifo_wr <= fifo_wr + 1'b1;
        if (fifo_pop)    fifo_rd <= fifo_rd + 1'b1;
        fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; the reset pointers and counters
  // guarantee no slot is read before it has been written.
  always_ff @(posedge clk) begin
    if (fetch_grant) begin
      aq_addr[aq_wr] <= pc;
    end
    if (fifo_push) begin
      fifo_inst[fifo_wr] <= imem_rdata_i;
      fifo_addr[fifo_wr] <= aq_addr[aq_rd];
    end
  end

endmodule
